// File: rtl/uart_receiver_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding (common with the
// transmitter) and oversampling constants.
package uart_receiver_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_START = 2'b01,
        ST_DATA  = 2'b10,
        ST_STOP  = 2'b11
    } uart_state_t;

    localparam int OVERSAMPLE = 16;
    localparam int MID_TICK   = 7;

endpackage

// File: rtl/uart_receiver_sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input; the reset value is
// parameterised so an idle-high line does not look like a start bit after reset.
module uart_receiver_sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk_100MHz,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// 16x-oversampled UART receiver (8N1 by default) delivering each word with a
// one-clock rx_done strobe and a framing-error flag taken from the stop bit.
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   ST_IDLE  | waiting for a falling edge on a line that has been seen high
//   ST_START | counting to mid start bit; line high there means false start
//   ST_DATA  | sampling DBITS data bits at mid-bit, LSB first
//   ST_STOP  | waiting to mid stop bit, then publishing word and error flag
module uart_receiver
    import uart_receiver_pkg::*;
#(
    parameter int DBITS   = 8,
    parameter int SB_TICK = 16
) (
    input  logic             clk_100MHz,
    input  logic             reset,
    input  logic             rx,
    input  logic             sample_tick,
    output logic [DBITS-1:0] data_out,
    output logic             rx_done,
    output logic             frame_err
);

    localparam int NB_W = (DBITS > 1) ? $clog2(DBITS) : 1;

    uart_state_t      state, state_next;
    logic [3:0]       tick, tick_next;
    logic [NB_W-1:0]  nbits, nbits_next;
    logic [DBITS-1:0] data_reg, data_next;
    logic [DBITS-1:0] data_out_next;
    logic             armed, armed_next;
    logic             done_next, ferr_next;
    logic             rx_s;

    uart_receiver_sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .d          (rx),
        .q          (rx_s)
    );

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            tick      <= '0;
            nbits     <= '0;
            data_reg  <= '0;
            armed     <= 1'b0;
            data_out  <= '0;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_next;
            tick      <= tick_next;
            nbits     <= nbits_next;
            data_reg  <= data_next;
            armed     <= armed_next;
            data_out  <= data_out_next;
            rx_done   <= done_next;
            frame_err <= ferr_next;
        end
    end

    always_comb begin
        state_next    = state;
        tick_next     = tick;
        nbits_next    = nbits;
        data_next     = data_reg;
        armed_next    = armed;
        data_out_next = data_out;
        done_next     = 1'b0;
        ferr_next     = frame_err;

        case (state)
            ST_IDLE: begin
                // armed gates the start edge so a held-low break cannot retrigger
                if (armed && !rx_s) begin
                    state_next = ST_START;
                    tick_next  = '0;
                    armed_next = 1'b0;
                end else if (rx_s) begin
                    armed_next = 1'b1;
                end
            end
            ST_START: begin
                if (sample_tick) begin
                    if (tick == 4'(MID_TICK)) begin
                        if (!rx_s) begin
                            state_next = ST_DATA;
                            tick_next  = '0;
                            nbits_next = '0;
                        end else begin
                            state_next = ST_IDLE;
                        end
                    end else begin
                        tick_next = tick + 4'd1;
                    end
                end
            end
            ST_DATA: begin
                if (sample_tick) begin
                    if (tick == 4'(OVERSAMPLE - 1)) begin
                        data_next = {rx_s, data_reg[DBITS-1:1]};
                        tick_next = '0;
                        if (nbits == NB_W'(DBITS - 1))
                            state_next = ST_STOP;
                        else
                            nbits_next = nbits + 1'b1;
                    end else begin
                        tick_next = tick + 4'd1;
                    end
                end
            end
            ST_STOP: begin
                if (sample_tick) begin
                    if (tick == 4'(SB_TICK - 1)) begin
                        state_next    = ST_IDLE;
                        done_next     = 1'b1;
                        data_out_next = data_reg;
                        ferr_next     = ~rx_s;
                    end else begin
                        tick_next = tick + 4'd1;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule
